// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, fetch FSM states and the RV32
// instruction field positions used by both fetch and decode.
package cpu_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // RV32 base-format field positions (LSB of each field)
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;
  localparam int unsigned F7_W    = 7;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a fetch request
    S_WAIT = 2'd1,  // one request outstanding
    S_HOLD = 2'd2,  // response buffered while decode is stalled
    S_DROP = 2'd3   // discard the next (stale) response
  } fetch_state_e;

endpackage

// File: rtl/if_buf.sv
// One-entry instruction/PC holding buffer used while decode is stalled.
module if_buf #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_i,
  input  logic               unld_i,
  input  logic               clr_i,
  input  logic [D_WIDTH-1:0] instr_i,
  input  logic [A_WIDTH-1:0] pc_i,
  output logic               vld_o,
  output logic [D_WIDTH-1:0] instr_o,
  output logic [A_WIDTH-1:0] pc_o
);

  logic               vld_q;
  logic [D_WIDTH-1:0] instr_q;
  logic [A_WIDTH-1:0] pc_q;

  // Capture on load; clear/unload only drop the valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clr_i || unld_i) begin
      vld_q   <= 1'b0;
    end else if (ld_i) begin
      vld_q   <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign vld_o   = vld_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/gnt/rvalid fetch FSM and IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN: word-aligns redirect targets and
// raises a sticky misalign_err on a misaligned redirect.
module if_stage
  import cpu_pkg::*;
#(
  parameter int              D_WIDTH  = 32,
  parameter int              A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int              N_REGS   = 32,
  parameter int              RF_SIZE  = $clog2(N_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [D_WIDTH-1:0] imem_rdata,
  output logic [D_WIDTH-1:0] instr_id,
  output logic [A_WIDTH-1:0] pc_id,
  output logic               valid_id,
  output logic [RF_SIZE-1:0] rs1_id,
  output logic [RF_SIZE-1:0] rs2_id,
  output logic [RF_SIZE-1:0] rd_id,
  output logic [6:0]         opcode_id,
  output logic [2:0]         funct3_id,
  output logic [6:0]         funct7_id,
  output logic               misalign_err
);

  fetch_state_e       state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d, fpc_q, fpc_d, pcid_q, pcid_d;
  logic [D_WIDTH-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               buf_ld, buf_unld, buf_clr, buf_vld;
  logic [D_WIDTH-1:0] buf_instr;
  logic [A_WIDTH-1:0] buf_pc;
  logic [A_WIDTH-1:0] redir_pc;
  logic               gnt;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;
  assign redir_pc = {redirect_pc[A_WIDTH-1:2], 2'b00};
  // Sticky until reset: any flush to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (!rst)                                 misalign_q <= 1'b0;
    else if (flush && redirect_pc[1:0] != '0) misalign_q <= 1'b1;
  end
  assign misalign_err = misalign_q;
`else
  assign redir_pc     = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  assign imem_req  = rst && (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign gnt       = imem_req && imem_gnt;

  if_buf #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (buf_ld),
    .unld_i  (buf_unld),
    .clr_i   (buf_clr),
    .instr_i (imem_rdata),
    .pc_i    (fpc_q),
    .vld_o   (buf_vld),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // Next state, PC and IF/ID contents; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    instr_d  = instr_q;
    pcid_d   = pcid_q;
    valid_d  = valid_q;
    buf_ld   = 1'b0;
    buf_unld = 1'b0;
    buf_clr  = 1'b0;
    // Decode consumes IF/ID every unstalled cycle: default to a bubble.
    if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
    unique case (state_q)
      S_REQ: if (gnt) begin
        pc_d    = pc_q + A_WIDTH'(4);
        fpc_d   = pc_q;
        state_d = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) begin
        if (stall) begin
          buf_ld  = 1'b1;
          state_d = S_HOLD;
        end else begin
          instr_d = imem_rdata;
          pcid_d  = fpc_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_HOLD: if (!stall && buf_vld) begin
        instr_d  = buf_instr;
        pcid_d   = buf_pc;
        valid_d  = 1'b1;
        buf_unld = 1'b1;
        state_d  = S_REQ;
      end
      S_DROP: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    if (flush) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      instr_d = NOP;
      buf_ld  = 1'b0;
      buf_clr = 1'b1;
      // A stale response is still owed if a grant was taken and its data
      // has not arrived yet (also true of a pending drop).
      if ((state_q == S_REQ && gnt) ||
          (state_q == S_WAIT && !imem_rvalid) ||
          (state_q == S_DROP && !imem_rvalid))
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      fpc_q   <= '0;
      instr_q <= NOP;
      pcid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      pcid_q  <= pcid_d;
      valid_q <= valid_d;
    end
  end

  assign instr_id  = instr_q;
  assign pc_id     = pcid_q;
  assign valid_id  = valid_q;
  assign opcode_id = instr_q[OPC_LSB +: OPC_W];
  assign rd_id     = instr_q[RD_LSB  +: RF_SIZE];
  assign funct3_id = instr_q[F3_LSB  +: F3_W];
  assign rs1_id    = instr_q[RS1_LSB +: RF_SIZE];
  assign rs2_id    = instr_q[RS2_LSB +: RF_SIZE];
  assign funct7_id = instr_q[F7_LSB  +: F7_W];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus reset and
// misaligned-redirect sequences (IF_MISALIGN_CHK_EN aware).
module tb_if_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_id, pc_id;
  logic        valid_id, misalign_err;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [6:0]  opcode_id, funct7_id;
  logic [2:0]  funct3_id;

  logic gnt_en = 1'b0;
  logic lat    = 1'b0;
  logic pend;
  logic [31:0] pend_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .opcode_id(opcode_id),
    .funct3_id(funct3_id), .funct7_id(funct7_id), .misalign_err(misalign_err)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0050_0093;
    else if (a == 32'h4) return 32'h00A0_0113;
    else                 return {a[11:0], 20'h00013};
  endfunction

  // Memory model: grant when enabled, response 1 or 2 cycles later.
  assign imem_gnt = gnt_en & imem_req;
  always @(posedge clk) begin
    if (!rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
      pend        <= 1'b0;
      pend_data   <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= pend_data;
        pend        <= 1'b0;
      end
      if (imem_req && imem_gnt) begin
        if (lat) begin
          pend      <= 1'b1;
          pend_data <= memf(imem_addr);
        end else begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= memf(imem_addr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st, fl, ge, lt;
    logic [31:0] redir;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pcid;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(input logic st, fl, ge, lt, input logic [31:0] redir,
                              input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] instr, pcid);
    vec_t v;
    v.st = st; v.fl = fl; v.ge = ge; v.lt = lt; v.redir = redir;
    v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.pcid = pcid;
    return v;
  endfunction

  initial begin
    // Zero-wait fetches from reset
    tv[0]  = mk(0,0,1,0,0,     1,32'h000,0,NOPI,0);
    tv[1]  = mk(0,0,1,0,0,     0,32'h004,0,NOPI,0);
    tv[2]  = mk(0,0,1,0,0,     1,32'h004,1,32'h0050_0093,32'h0);
    tv[3]  = mk(0,0,1,0,0,     0,32'h008,0,NOPI,0);
    // Stall 3 cycles while the response to 8 arrives
    tv[4]  = mk(1,0,1,0,0,     1,32'h008,1,32'h00A0_0113,32'h4);
    tv[5]  = mk(1,0,1,0,0,     0,32'h00C,1,32'h00A0_0113,32'h4);
    tv[6]  = mk(1,0,1,0,0,     0,32'h00C,1,32'h00A0_0113,32'h4);
    tv[7]  = mk(0,0,1,0,0,     0,32'h00C,1,32'h00A0_0113,32'h4);
    tv[8]  = mk(0,0,1,0,0,     1,32'h00C,1,32'h0080_0013,32'h8);
    tv[9]  = mk(0,0,1,0,0,     0,32'h010,0,NOPI,0);
    // Flush in S_WAIT, stale response one cycle later
    tv[10] = mk(0,0,1,1,0,     1,32'h010,1,32'h00C0_0013,32'hC);
    tv[11] = mk(0,1,1,1,32'h100,0,32'h014,0,NOPI,0);
    tv[12] = mk(0,0,1,1,0,     0,32'h100,0,NOPI,0);
    tv[13] = mk(0,0,1,0,0,     1,32'h100,0,NOPI,0);
    tv[14] = mk(0,0,1,0,0,     0,32'h104,0,NOPI,0);
    // Flush together with stall while a grant is taken
    tv[15] = mk(1,1,1,0,32'h200,1,32'h104,1,32'h1000_0013,32'h100);
    tv[16] = mk(0,0,1,0,0,     0,32'h200,0,NOPI,0);
    // Grant held low 4 cycles
    tv[17] = mk(0,0,0,0,0,     1,32'h200,0,NOPI,0);
    tv[18] = mk(0,0,0,0,0,     1,32'h200,0,NOPI,0);
    tv[19] = mk(0,0,0,0,0,     1,32'h200,0,NOPI,0);
    tv[20] = mk(0,0,0,0,0,     1,32'h200,0,NOPI,0);
    tv[21] = mk(0,0,1,0,0,     1,32'h200,0,NOPI,0);
    tv[22] = mk(0,0,1,0,0,     0,32'h204,0,NOPI,0);
    tv[23] = mk(0,0,0,0,0,     1,32'h204,1,32'h2000_0013,32'h200);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req",   {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, valid_id}, 0);
    chk("rst_instr", instr_id, NOPI);
    chk("rst_pcid",  pc_id, 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_mis",   {31'b0, misalign_err}, 0);

    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      stall = tv[i].st; flush = tv[i].fl; gnt_en = tv[i].ge; lat = tv[i].lt;
      redirect_pc = tv[i].redir;
      #1;
      chk($sformatf("c%0d_req", i),   {31'b0, imem_req}, {31'b0, tv[i].req});
      chk($sformatf("c%0d_addr", i),  imem_addr, tv[i].addr);
      chk($sformatf("c%0d_valid", i), {31'b0, valid_id}, {31'b0, tv[i].vld});
      chk($sformatf("c%0d_instr", i), instr_id, tv[i].instr);
      if (tv[i].vld) chk($sformatf("c%0d_pcid", i), pc_id, tv[i].pcid);
      chk($sformatf("c%0d_rd", i),  {27'b0, rd_id},  {27'b0, tv[i].instr[11:7]});
      chk($sformatf("c%0d_rs1", i), {27'b0, rs1_id}, {27'b0, tv[i].instr[19:15]});
      chk($sformatf("c%0d_rs2", i), {27'b0, rs2_id}, {27'b0, tv[i].instr[24:20]});
      chk($sformatf("c%0d_opc", i), {25'b0, opcode_id}, {25'b0, tv[i].instr[6:0]});
      chk($sformatf("c%0d_f3", i),  {29'b0, funct3_id}, {29'b0, tv[i].instr[14:12]});
      chk($sformatf("c%0d_f7", i),  {25'b0, funct7_id}, {25'b0, tv[i].instr[31:25]});
      if (i == 2) begin
        chk("first_rd",  {27'b0, rd_id}, 1);
        chk("first_opc", {25'b0, opcode_id}, 32'h13);
      end
      @(negedge clk);
    end

    // Redirect to 0x102 from S_REQ with no grant
    stall = 0; gnt_en = 0; flush = 1; redirect_pc = 32'h102;
    @(negedge clk);
    flush = 0; redirect_pc = 0;
    #1;
    chk("mis_req", {31'b0, imem_req}, 1);
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_err",  {31'b0, misalign_err}, 1);
    @(negedge clk); #1;
    chk("mis_sticky", {31'b0, misalign_err}, 1);
`else
    chk("mis_addr", imem_addr, 32'h102);
    chk("mis_err",  {31'b0, misalign_err}, 0);
`endif

    // Reset again mid-run
    @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    chk("rst2_req",   {31'b0, imem_req}, 0);
    chk("rst2_addr",  imem_addr, 0);
    chk("rst2_valid", {31'b0, valid_id}, 0);
    chk("rst2_instr", instr_id, NOPI);
    chk("rst2_mis",   {31'b0, misalign_err}, 0);
    rst = 1; #1;
    chk("rst2_rel_req", {31'b0, imem_req}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
